// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: decode-stage forwarding and hazard tracker.
// Follows the destination registers of in-flight producers through STAGES
// pipeline stages, plus one variable-latency multiply/divide result, and
// derives per-operand bypass selects and a decode stall.
// Optional: define HAZARD_STATS_EN to enable the saturating stall-cycle counter.
module fwd_hazard_scoreboard #(
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int FW         = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rs,
    input  logic [4:0]    issue_rt,
    input  logic          issue_use_rs,
    input  logic          issue_use_rt,
    input  logic          issue_wr,
    input  logic [4:0]    issue_dst,
    input  logic [1:0]    issue_class,
    input  logic          hold,
    input  logic          flush,
    input  logic          long_done,
    output logic [FW-1:0] fwd_a,
    output logic [FW-1:0] fwd_b,
    output logic          stall,
    output logic          long_busy,
    output logic [31:0]   stall_cycles
);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    logic [STAGES:1]      ent_v;
    logic [STAGES:1][4:0] ent_dst;
    logic [STAGES:1][1:0] ent_cls;
    logic [4:0]           long_dst;

    logic [FW:0] res_a;
    logic [FW:0] res_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        long_issue;
    logic        alloc_long;

    // Resolves one source operand to {hazard, select}; the youngest matching stage wins,
    // a load younger than LOAD_READY is a hazard, and the long-op result bypasses only on long_done.
    function automatic logic [FW:0] resolve(
        input logic [4:0]           src,
        input logic                 use_src,
        input logic [STAGES:1]      v,
        input logic [STAGES:1][4:0] dst,
        input logic [STAGES:1][1:0] cls,
        input logic                 busy,
        input logic [4:0]           ldst,
        input logic                 done
    );
        logic          found;
        logic          haz;
        logic [FW-1:0] sel;
        found = 1'b0;
        haz   = 1'b0;
        sel   = '0;
        if (use_src && src != 5'd0) begin
            for (int k = 1; k <= STAGES; k++) begin
                if (!found && v[k] && dst[k] == src) begin
                    found = 1'b1;
                    if (cls[k] != CLS_LOAD || k >= LOAD_READY) begin
                        sel = FW'(k);
                    end else begin
                        haz = 1'b1;
                    end
                end
            end
            if (!found && busy && ldst == src) begin
                if (done) begin
                    sel = FW'(STAGES + 1);
                end else begin
                    haz = 1'b1;
                end
            end
        end
        return {haz, sel};
    endfunction

    // Combinational bypass selects and decode stall for the instruction in decode.
    always_comb begin
        res_a      = resolve(issue_rs, issue_use_rs, ent_v, ent_dst, ent_cls, long_busy, long_dst, long_done);
        res_b      = resolve(issue_rt, issue_use_rt, ent_v, ent_dst, ent_cls, long_busy, long_dst, long_done);
        hazard_a   = res_a[FW];
        hazard_b   = res_b[FW];
        fwd_a      = res_a[FW-1:0];
        fwd_b      = res_b[FW-1:0];
        long_issue = (issue_class == CLS_LONG);
        stall      = issue_valid & (hazard_a | hazard_b | (long_issue & long_busy & ~long_done));
        alloc_long = issue_valid & long_issue & ~stall & ~flush & ~hold;
    end

    // Producer shift register: frozen under hold, otherwise advances one stage with decode entering stage 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_v   <= '0;
            ent_dst <= '0;
            ent_cls <= '0;
        end else if (!hold) begin
            for (int k = STAGES; k >= 2; k--) begin
                ent_v[k]   <= ent_v[k-1];
                ent_dst[k] <= ent_dst[k-1];
                ent_cls[k] <= ent_cls[k-1];
            end
            ent_v[1]   <= issue_valid & issue_wr & ~stall & ~flush & ~long_issue;
            ent_dst[1] <= issue_dst;
            ent_cls[1] <= issue_class;
        end
    end

    // Long-op tracker: a new allocation takes priority over a completion in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            long_busy <= 1'b0;
            long_dst  <= 5'd0;
        end else if (alloc_long) begin
            long_busy <= 1'b1;
            long_dst  <= issue_wr ? issue_dst : 5'd0;
        end else if (long_done && long_busy) begin
            long_busy <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of cycles in which decode stalled while the backend was running.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= 32'd0;
        end else if (stall && !hold && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
